softmc_pcie_bridge: RTL and testbench

//  Parametrised RIFFA-channel bridge between PCIe host and SoftMC core, one clock domain.
//  RX side: unpacks 32-bit DRAM instructions from C_PCI_DATA_WIDTH words and issues them on app_en/app_ack.
//  TX side: pops readback-FIFO entries (DQ_WIDTH*4 bits) and sends each as one TX transaction of ceil beats.

---
 rtl/softmc_pcie_bridge_if.sv | 63 ++++++
 rtl/softmc_pcie_bridge.sv | 191 +++++++++++++++++++
 tb/tb_softmc_pcie_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmc_pcie_bridge_if.sv
// ============================================================================
//  Module      : softmc_pcie_bridge_if
//  Description : RIFFA channel, SoftMC instruction and readback-FIFO signals
//                seen by the SoftMC PCIe bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface softmc_pcie_bridge_if #(
   parameter int C_PCI_DATA_WIDTH = 64,
   parameter int DQ_WIDTH         = 64
);
   logic                        CHNL_RX_CLK;
   logic                        CHNL_RX;
   logic                        CHNL_RX_ACK;
   logic                        CHNL_RX_LAST;
   logic [31:0]                 CHNL_RX_LEN;
   logic [30:0]                 CHNL_RX_OFF;
   logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
   logic                        CHNL_RX_DATA_VALID;
   logic                        CHNL_RX_DATA_REN;

   logic                        CHNL_TX_CLK;
   logic                        CHNL_TX;
   logic                        CHNL_TX_ACK;
   logic                        CHNL_TX_LAST;
   logic [31:0]                 CHNL_TX_LEN;
   logic [30:0]                 CHNL_TX_OFF;
   logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA;
   logic                        CHNL_TX_DATA_VALID;
   logic                        CHNL_TX_DATA_REN;

   logic                        app_en;
   logic                        app_ack;
   logic [31:0]                 app_instr;

   logic                        rdback_fifo_empty;
   logic                        rdback_fifo_rden;
   logic [DQ_WIDTH*4-1:0]       rdback_data;

   // master: the bridge; slave: the host channel, memory controller and FIFO
   modport master (
      output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
      output CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
      output CHNL_TX_DATA, CHNL_TX_DATA_VALID,
      output app_en, app_instr, rdback_fifo_rden,
      input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
      input  CHNL_RX_DATA_VALID, CHNL_TX_ACK, CHNL_TX_DATA_REN,
      input  app_ack, rdback_fifo_empty, rdback_data
   );

   modport slave (
      input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
      input  CHNL_TX_CLK, CHNL_TX, CHNL_TX_LAST, CHNL_TX_LEN, CHNL_TX_OFF,
      input  CHNL_TX_DATA, CHNL_TX_DATA_VALID,
      input  app_en, app_instr, rdback_fifo_rden,
      output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF, CHNL_RX_DATA,
      output CHNL_RX_DATA_VALID, CHNL_TX_ACK, CHNL_TX_DATA_REN,
      output app_ack, rdback_fifo_empty, rdback_data
   );
endinterface

`default_nettype wire

// File: rtl/softmc_pcie_bridge.sv
// ============================================================================
//  Module      : softmc_pcie_bridge
//  Description : RIFFA <-> SoftMC bridge. RX unpacks 32-bit instructions onto
//                app_en/app_ack; TX streams readback-FIFO entries as bursts.
//                Define SOFTMC_PCIE_PERF_CNT_EN to add instr/rdback counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmc_pcie_bridge #(
   parameter int C_PCI_DATA_WIDTH = 64,
   parameter int DQ_WIDTH         = 64
) (
   input  wire logic            clk,
   input  wire logic            rst,
   softmc_pcie_bridge_if.master bus
`ifdef SOFTMC_PCIE_PERF_CNT_EN
   ,
   output logic [31:0]          instr_count,
   output logic [31:0]          rdback_count
`endif
);

   localparam int SLOTS = C_PCI_DATA_WIDTH / 32;
   localparam int BEATS = DQ_WIDTH * 4 / C_PCI_DATA_WIDTH;
   localparam int TXLEN = DQ_WIDTH / 8;
   localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CW    = $clog2(SLOTS + 1);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [0:0] {
      TX_IDLE = 1'b0,
      TX_SEND = 1'b1
   } tx_state_t;

   // ------------------------------------------------------------------ RX
   logic                        r_rx_d;
   logic                        r_rx_ack;
   logic [31:0]                 r_remaining;
   logic [C_PCI_DATA_WIDTH-1:0] r_word;
   logic [SW-1:0]               r_slot;
   logic [CW-1:0]               r_cnt;

   logic                        w_rx_rise;
   logic                        w_held;
   logic                        w_last_slot;
   logic                        w_accept;
   logic                        w_rx_ren;
   logic                        w_capture;
   logic [CW-1:0]               w_take;

   assign w_rx_rise   = bus.CHNL_RX & ~r_rx_d;
   assign w_held      = (r_cnt != '0);
   assign w_last_slot = (CW'(r_slot) == (r_cnt - CW'(1)));
   assign w_accept    = w_held & bus.app_ack;
   // Refill in the same cycle the last held slot is accepted, so no bubble
   assign w_rx_ren    = ~w_held | (w_accept & w_last_slot);
   assign w_capture   = bus.CHNL_RX_DATA_VALID & w_rx_ren;
   assign w_take      = (r_remaining >= 32'(SLOTS)) ? CW'(SLOTS) : r_remaining[CW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_d      <= 1'b0;
         r_rx_ack    <= 1'b0;
         r_remaining <= '0;
         r_word      <= '0;
         r_slot      <= '0;
         r_cnt       <= '0;
      end else begin
         r_rx_d   <= bus.CHNL_RX;
         r_rx_ack <= w_rx_rise;

         if (w_capture) begin
            r_word <= bus.CHNL_RX_DATA;
            r_slot <= '0;
            r_cnt  <= w_take;
         end else if (w_accept) begin
            if (w_last_slot) begin
               r_cnt  <= '0;
               r_slot <= '0;
            end else begin
               r_slot <= r_slot + 1'b1;
            end
         end

         if (w_rx_rise) begin
            r_remaining <= bus.CHNL_RX_LEN;
         end else if (w_capture) begin
            r_remaining <= r_remaining - 32'(w_take);
         end
      end
   end

   assign bus.CHNL_RX_CLK      = clk;
   assign bus.CHNL_RX_ACK      = r_rx_ack;
   assign bus.CHNL_RX_DATA_REN = w_rx_ren;
   assign bus.app_en           = w_held;
   assign bus.app_instr        = r_word[32*r_slot +: 32];

   // ------------------------------------------------------------------ TX
   tx_state_t             r_state;
   tx_state_t             w_state_nxt;
   logic [BW-1:0]         r_beat;
   logic [BW-1:0]         w_beat_nxt;
   logic [DQ_WIDTH*4-1:0] r_hold;
   logic                  w_load;
   logic                  w_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TX_IDLE;
         r_beat  <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         if (w_load) begin
            r_hold <= bus.rdback_data;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_load      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (!bus.rdback_fifo_empty) begin
               w_load      = 1'b1;
               w_beat_nxt  = '0;
               w_state_nxt = TX_SEND;
            end
         end
         TX_SEND: begin
            if (bus.CHNL_TX_DATA_REN) begin
               if (r_beat == BW'(BEATS - 1)) begin
                  w_done      = 1'b1;
                  w_beat_nxt  = '0;
                  w_state_nxt = TX_IDLE;
               end else begin
                  w_beat_nxt  = r_beat + 1'b1;
               end
            end
         end
         default: w_state_nxt = TX_IDLE;
      endcase
   end

   // Pop request is masked during reset so the FIFO never loses an entry then
   assign bus.rdback_fifo_rden   = (r_state == TX_IDLE) & ~rst;
   assign bus.CHNL_TX_CLK        = clk;
   assign bus.CHNL_TX            = (r_state == TX_SEND);
   assign bus.CHNL_TX_DATA_VALID = (r_state == TX_SEND);
   assign bus.CHNL_TX_LAST       = 1'b1;
   assign bus.CHNL_TX_LEN        = 32'(TXLEN);
   assign bus.CHNL_TX_OFF        = '0;
   assign bus.CHNL_TX_DATA       = r_hold[r_beat*C_PCI_DATA_WIDTH +: C_PCI_DATA_WIDTH];

   logic w_unused;
   assign w_unused = &{1'b0, bus.CHNL_RX_LAST, bus.CHNL_RX_OFF, bus.CHNL_TX_ACK};

`ifdef SOFTMC_PCIE_PERF_CNT_EN
   logic [31:0] r_instr_count;
   logic [31:0] r_rdback_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_instr_count  <= '0;
         r_rdback_count <= '0;
      end else begin
         if (w_accept) begin
            r_instr_count <= r_instr_count + 32'd1;
         end
         if (w_done) begin
            r_rdback_count <= r_rdback_count + 32'd1;
         end
      end
   end

   assign instr_count  = r_instr_count;
   assign rdback_count = r_rdback_count;
`else
   logic w_unused_done;
   assign w_unused_done = w_done;
`endif

endmodule

`default_nettype wire

// File: tb/tb_softmc_pcie_bridge.sv
// ============================================================================
//  Module      : tb_softmc_pcie_bridge
//  Description : Scoreboard bench for softmc_pcie_bridge (64-bit PCIe, DQ 64).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softmc_pcie_bridge;

   localparam int W     = 64;
   localparam int DQ    = 64;
   localparam int BEATS = DQ * 4 / W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   softmc_pcie_bridge_if #(.C_PCI_DATA_WIDTH(W), .DQ_WIDTH(DQ)) bif ();

`ifdef SOFTMC_PCIE_PERF_CNT_EN
   logic [31:0] instr_count;
   logic [31:0] rdback_count;
`endif

   softmc_pcie_bridge #(.C_PCI_DATA_WIDTH(W), .DQ_WIDTH(DQ)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bif.master)
`ifdef SOFTMC_PCIE_PERF_CNT_EN
      ,
      .instr_count  (instr_count),
      .rdback_count (rdback_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // scoreboards: written by stimulus, read by the monitor
   logic [31:0]     exp_instr [0:63];
   int              ins_wr = 0;
   int              ins_rd = 0;
   logic [W-1:0]    exp_beat  [0:63];
   int              tx_wr = 0;
   int              tx_rd = 0;
   int              hs_cyc    [0:63];
   int              hs_n = 0;
   logic [4*DQ-1:0] fifo_mem  [0:7];
   int              fifo_wr = 0;
   int              fifo_rd = 0;

   logic tog_en    = 1'b0;
   logic ren_force = 1'b0;

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // first-word-fall-through FIFO model
   initial begin
      logic will_pop;
      will_pop = 1'b0;
      bif.rdback_fifo_empty = 1'b1;
      bif.rdback_data       = '0;
      forever begin
         @(negedge clk);
         if (will_pop) fifo_rd++;
         bif.rdback_fifo_empty = (fifo_rd == fifo_wr);
         bif.rdback_data       = (fifo_rd == fifo_wr) ? '0 : fifo_mem[fifo_rd % 8];
         will_pop = bif.rdback_fifo_rden && !bif.rdback_fifo_empty;
      end
   end

   // host TX read-enable: toggling or forced level
   initial begin
      bif.CHNL_TX_DATA_REN = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bif.CHNL_TX_DATA_REN = tog_en ? ~bif.CHNL_TX_DATA_REN : ren_force;
      end
   end

   // monitor: every handshake pops and compares one expected item
   initial begin
      logic tx_last_prev;
      int   beat;
      tx_last_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bif.app_en && bif.app_ack) begin
            if (ins_rd == ins_wr) begin
               check_eq("app_sb_underflow", ins_wr - ins_rd, 1);
            end else begin
               check_eq("app_instr", bif.app_instr, exp_instr[ins_rd % 64]);
               ins_rd++;
            end
            if (hs_n < 64) hs_cyc[hs_n] = cyc;
            hs_n++;
         end
         if (tx_last_prev) check_eq("tx_drop_after_last", bif.CHNL_TX, 0);
         tx_last_prev = 1'b0;
         if (bif.CHNL_TX_DATA_VALID && bif.CHNL_TX_DATA_REN) begin
            beat = tx_rd % BEATS;
            if (tx_rd == tx_wr) begin
               check_eq("tx_sb_underflow", tx_wr - tx_rd, 1);
            end else begin
               check_eq("tx_beat", bif.CHNL_TX_DATA, exp_beat[tx_rd % 64]);
               check_eq("tx_len", bif.CHNL_TX_LEN, 32'd8);
               tx_rd++;
            end
            tx_last_prev = (beat == BEATS - 1);
         end
         if (bif.CHNL_TX) check_eq("pop_in_send", bif.rdback_fifo_rden, 0);
      end
   end

   task automatic push_instr(input logic [31:0] v);
      exp_instr[ins_wr % 64] = v;
      ins_wr++;
   endtask

   task automatic push_entry(input logic [4*DQ-1:0] d, input int nbeats);
      fifo_mem[fifo_wr % 8] = d;
      fifo_wr++;
      for (int b = 0; b < nbeats; b++) begin
         exp_beat[tx_wr % 64] = d[b*W +: W];
         tx_wr++;
      end
   endtask

   // open a new RX transaction and check the one-cycle ack shape
   task automatic start_chnl(input logic [31:0] len);
      logic [3:0] ack_vec;
      bif.CHNL_RX = 1'b0;
      @(posedge clk);
      #1;
      bif.CHNL_RX_LEN = len;
      bif.CHNL_RX     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ack_vec[i] = bif.CHNL_RX_ACK;
      end
      check_eq("rx_ack_pulse", ack_vec, 4'b0010);
      @(posedge clk);
      #1;
   endtask

   task automatic rx_present(input logic [W-1:0] d);
      bif.CHNL_RX_DATA       = d;
      bif.CHNL_RX_DATA_VALID = 1'b1;
   endtask

   task automatic rx_wait();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bif.CHNL_RX_DATA_REN && n < 100);
      check_eq("rx_word_taken", bif.CHNL_RX_DATA_REN, 1);
      @(posedge clk);
      #1;
      bif.CHNL_RX_DATA_VALID = 1'b0;
   endtask

   task automatic rx_send(input logic [W-1:0] d);
      rx_present(d);
      rx_wait();
   endtask

   task automatic wait_app_drain();
      int n;
      n = 0;
      while ((ins_rd != ins_wr || bif.app_en) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("app_drain", ins_wr - ins_rd, 0);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4*DQ-1:0] rand_entry();
      logic [4*DQ-1:0] d;
      for (int i = 0; i < 4*DQ/32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   initial begin
      int              hs0;
      int              n;
      logic [4*DQ-1:0] d3;

      bif.CHNL_RX            = 1'b0;
      bif.CHNL_RX_LAST       = 1'b0;
      bif.CHNL_RX_LEN        = '0;
      bif.CHNL_RX_OFF        = '0;
      bif.CHNL_RX_DATA       = '0;
      bif.CHNL_RX_DATA_VALID = 1'b0;
      bif.CHNL_TX_ACK        = 1'b0;
      bif.app_ack            = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_rx_ack",   bif.CHNL_RX_ACK, 0);
      check_eq("rst_app_en",   bif.app_en, 0);
      check_eq("rst_tx",       bif.CHNL_TX, 0);
      check_eq("rst_tx_valid", bif.CHNL_TX_DATA_VALID, 0);
      check_eq("rst_rden",     bif.rdback_fifo_rden, 0);
      check_eq("tx_last",      bif.CHNL_TX_LAST, 1);
      check_eq("tx_len_const", bif.CHNL_TX_LEN, 32'd8);
      check_eq("tx_off",       bif.CHNL_TX_OFF, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // four instructions back to back
      start_chnl(32'd4);
      push_instr(32'hA000_0001); push_instr(32'hB000_0002);
      push_instr(32'hC000_0003); push_instr(32'hD000_0004);
      hs0 = hs_n;
      rx_send({32'hB000_0002, 32'hA000_0001});
      rx_send({32'hD000_0004, 32'hC000_0003});
      wait_app_drain();
      check_eq("t1_consecutive", hs_cyc[(hs0 + 3) % 64] - hs_cyc[hs0 % 64], 3);

      // odd length: upper slot of the last word is dropped
      start_chnl(32'd3);
      push_instr(32'h1111_0001); push_instr(32'h2222_0002); push_instr(32'h3333_0003);
      rx_send({32'h2222_0002, 32'h1111_0001});
      rx_send({32'hDEAD_BEEF, 32'h3333_0003});
      wait_app_drain();
      repeat (3) @(negedge clk);
      check_eq("t2_no_extra", ins_rd, ins_wr);
      @(posedge clk);
      #1;

      // back-pressure from the memory controller
      start_chnl(32'd4);
      push_instr(32'h5555_0001); push_instr(32'h6666_0002);
      push_instr(32'h7777_0003); push_instr(32'h8888_0004);
      bif.app_ack = 1'b0;
      rx_send({32'h6666_0002, 32'h5555_0001});
      rx_present({32'h8888_0004, 32'h7777_0003});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("bp_app_en", bif.app_en, 1);
         check_eq("bp_instr",  bif.app_instr, 32'h5555_0001);
         check_eq("bp_ren",    bif.CHNL_RX_DATA_REN, 0);
      end
      @(posedge clk);
      #1;
      bif.app_ack = 1'b1;
      rx_wait();
      wait_app_drain();

      // zero-length transaction: word consumed, nothing issued
      start_chnl(32'd0);
      rx_send({32'h9999_0002, 32'h9999_0001});
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("len0_app_en", bif.app_en, 0);
      end
`ifdef SOFTMC_PCIE_PERF_CNT_EN
      check_eq("instr_count", instr_count, 32'd11);
`endif
      @(posedge clk);
      #1;

      // two readback entries with toggling host read-enable
      tog_en = 1'b1;
      push_entry(rand_entry(), BEATS);
      push_entry(rand_entry(), BEATS);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((tx_rd != tx_wr || bif.CHNL_TX) && n < 400);
      check_eq("tx_drained", tx_wr - tx_rd, 0);
      check_eq("tx_pops", fifo_rd, 2);
`ifdef SOFTMC_PCIE_PERF_CNT_EN
      check_eq("rdback_count", rdback_count, 32'd2);
`endif

      // reset during beat 2 of a burst
      tog_en    = 1'b0;
      ren_force = 1'b0;
      repeat (3) @(negedge clk);
      d3 = rand_entry();
      push_entry(d3, 2);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bif.CHNL_TX && n < 50);
      check_eq("rst_burst_start", bif.CHNL_TX, 1);
      ren_force = 1'b1;
      @(negedge clk);
      @(negedge clk);
      ren_force = 1'b0;
      @(negedge clk);
      check_eq("beat2_data",  bif.CHNL_TX_DATA, d3[2*W +: W]);
      check_eq("beat2_valid", bif.CHNL_TX_DATA_VALID, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_rden_gated", bif.rdback_fifo_rden, 0);
      @(negedge clk);
      check_eq("mid_rst_tx",       bif.CHNL_TX, 0);
      check_eq("mid_rst_tx_valid", bif.CHNL_TX_DATA_VALID, 0);
      check_eq("mid_rst_app_en",   bif.app_en, 0);
`ifdef SOFTMC_PCIE_PERF_CNT_EN
      check_eq("rst_instr_count",  instr_count, 0);
      check_eq("rst_rdback_count", rdback_count, 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("post_rst_tx",   bif.CHNL_TX, 0);
      check_eq("fifo_pops_tot", fifo_rd, 3);
      check_eq("tx_sb_empty",   tx_wr - tx_rd, 0);
      check_eq("app_sb_empty",  ins_wr - ins_rd, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
